// File: rtl/systolic_pkg.sv
// Shared types and defaults for the systolic array and its operand feeder.
package systolic_pkg;

  localparam int unsigned MATRIX_SIZE_DEF = 4;
  localparam int unsigned DATA_WIDTH_DEF  = 8;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_CLEAR  = 2'd1,
    ST_STREAM = 2'd2,
    ST_DRAIN  = 2'd3
  } feeder_state_e;

  // Cycles needed after the last beat for the skewed wavefront to cross the array.
  function automatic int unsigned DRAIN_CYCLES(input int unsigned n);
    return 2 * n;
  endfunction

endpackage

// File: rtl/skew_delay_line.sv
// Fixed-depth register shift line used to delay one operand lane.
module skew_delay_line #(
  parameter int unsigned DEPTH = 1,
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] stage_q [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned s = 0; s < DEPTH; s++) stage_q[s] <= '0;
    end else begin
      stage_q[0] <= d_i;
      for (int unsigned s = 1; s < DEPTH; s++) stage_q[s] <= stage_q[s-1];
    end
  end

  assign q_o = stage_q[DEPTH-1];

endmodule

// File: rtl/systolic_feeder.sv
// Operand feeder/sequencer for systolic_array: skews K-slices onto the array edges and
// sequences clear/stream/drain. Define FEEDER_BUBBLE_CNT_EN to add the bubble_cnt port.
module systolic_feeder
  import systolic_pkg::*;
#(
  parameter int unsigned MATRIX_SIZE = MATRIX_SIZE_DEF,
  parameter int unsigned DATA_WIDTH  = DATA_WIDTH_DEF,
  parameter int unsigned MAX_K       = 255
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              start,
  input  logic [$clog2(MAX_K+1)-1:0]        k_len,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic [DATA_WIDTH*MATRIX_SIZE-1:0] a_col_flat,
  input  logic [DATA_WIDTH*MATRIX_SIZE-1:0] b_row_flat,
  output logic [DATA_WIDTH*MATRIX_SIZE-1:0] in_left_flat,
  output logic [DATA_WIDTH*MATRIX_SIZE-1:0] in_top_flat,
  output logic                              acc_rst,
  output logic                              acc_en,
  output logic                              shift_en,
  output logic                              busy,
  output logic                              done
`ifdef FEEDER_BUBBLE_CNT_EN
  , output logic [15:0]                     bubble_cnt
`endif
);

  localparam int unsigned KW      = $clog2(MAX_K + 1);
  localparam int unsigned LW      = DATA_WIDTH * MATRIX_SIZE;
  localparam int unsigned DRAIN_N = DRAIN_CYCLES(MATRIX_SIZE);
  localparam int unsigned DCW     = $clog2(DRAIN_N + 1);

  feeder_state_e  state_q, state_d;
  logic [KW-1:0]  k_q, k_d;
  logic [KW-1:0]  beat_q, beat_d;
  logic [DCW-1:0] drain_q, drain_d;
  logic [LW-1:0]  a_cap_q, a_cap_d;
  logic [LW-1:0]  b_cap_q, b_cap_d;
  logic           in_ready_q, in_ready_d;
  logic           acc_rst_q, acc_rst_d;
  logic           acc_en_q, acc_en_d;
  logic           shift_en_q, shift_en_d;
  logic           busy_q, busy_d;
  logic           done_q, done_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      k_q        <= '0;
      beat_q     <= '0;
      drain_q    <= '0;
      a_cap_q    <= '0;
      b_cap_q    <= '0;
      in_ready_q <= 1'b0;
      acc_rst_q  <= 1'b0;
      acc_en_q   <= 1'b0;
      shift_en_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      k_q        <= k_d;
      beat_q     <= beat_d;
      drain_q    <= drain_d;
      a_cap_q    <= a_cap_d;
      b_cap_q    <= b_cap_d;
      in_ready_q <= in_ready_d;
      acc_rst_q  <= acc_rst_d;
      acc_en_q   <= acc_en_d;
      shift_en_q <= shift_en_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  // Next state; the capture register holds zero on every cycle without an accepted beat.
  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    beat_d  = beat_q;
    drain_d = drain_q;
    a_cap_d = '0;
    b_cap_d = '0;
    done_d  = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          k_d     = k_len;
          beat_d  = '0;
          state_d = ST_CLEAR;
        end
      end
      ST_CLEAR: begin
        drain_d = '0;
        state_d = (k_q == '0) ? ST_DRAIN : ST_STREAM;
      end
      ST_STREAM: begin
        if (in_valid) begin
          a_cap_d = a_col_flat;
          b_cap_d = b_row_flat;
          beat_d  = beat_q + KW'(1);
          if (beat_d == k_q) begin
            drain_d = '0;
            state_d = ST_DRAIN;
          end
        end
      end
      ST_DRAIN: begin
        drain_d = drain_q + DCW'(1);
        if (drain_q == DCW'(DRAIN_N - 1)) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Controls are decoded from the next state so they leave registers aligned with it.
    in_ready_d = (state_d == ST_STREAM);
    acc_rst_d  = (state_d == ST_CLEAR);
    acc_en_d   = (state_d == ST_STREAM) || (state_d == ST_DRAIN);
    shift_en_d = acc_en_d;
    busy_d     = (state_d != ST_IDLE);
  end

  assign in_ready = in_ready_q;
  assign acc_rst  = acc_rst_q;
  assign acc_en   = acc_en_q;
  assign shift_en = shift_en_q;
  assign busy     = busy_q;
  assign done     = done_q;

  for (genvar i = 0; i < MATRIX_SIZE; i++) begin : g_lane
    skew_delay_line #(
      .DEPTH(i + 1),
      .WIDTH(DATA_WIDTH)
    ) u_left (
      .clk  (clk),
      .rst_n(rst_n),
      .d_i  (a_cap_q[i*DATA_WIDTH +: DATA_WIDTH]),
      .q_o  (in_left_flat[i*DATA_WIDTH +: DATA_WIDTH])
    );
    skew_delay_line #(
      .DEPTH(i + 1),
      .WIDTH(DATA_WIDTH)
    ) u_top (
      .clk  (clk),
      .rst_n(rst_n),
      .d_i  (b_cap_q[i*DATA_WIDTH +: DATA_WIDTH]),
      .q_o  (in_top_flat[i*DATA_WIDTH +: DATA_WIDTH])
    );
  end

`ifdef FEEDER_BUBBLE_CNT_EN
  logic [15:0] bubble_q, bubble_d;

  // Saturating count of zero beats injected during the current job.
  always_comb begin
    bubble_d = bubble_q;
    if (state_q == ST_CLEAR) begin
      bubble_d = '0;
    end else if ((state_q == ST_STREAM) && !in_valid && (bubble_q != 16'hFFFF)) begin
      bubble_d = bubble_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) bubble_q <= '0;
    else        bubble_q <= bubble_d;
  end

  assign bubble_cnt = bubble_q;
`endif

endmodule

// File: tb/tb_systolic_feeder.sv
// Directed bench for systolic_feeder with a cycle-level expectation table and an array model.
module tb_systolic_feeder;

  localparam int N       = 4;
  localparam int DW      = 8;
  localparam int LW      = N * DW;
  localparam int CYC_MAX = 1024;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic [7:0]    k_len;
  logic          in_valid;
  logic          in_ready;
  logic [LW-1:0] a_col_flat, b_row_flat;
  logic [LW-1:0] in_left_flat, in_top_flat;
  logic          acc_rst, acc_en, shift_en, busy, done;
`ifdef FEEDER_BUBBLE_CNT_EN
  logic [15:0]   bubble_cnt;
`endif

  systolic_feeder #(.MATRIX_SIZE(N), .DATA_WIDTH(DW), .MAX_K(255)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .k_len       (k_len),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .a_col_flat  (a_col_flat),
    .b_row_flat  (b_row_flat),
    .in_left_flat(in_left_flat),
    .in_top_flat (in_top_flat),
    .acc_rst     (acc_rst),
    .acc_en      (acc_en),
    .shift_en    (shift_en),
    .busy        (busy),
    .done        (done)
`ifdef FEEDER_BUBBLE_CNT_EN
    , .bubble_cnt(bubble_cnt)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  // Expected values visible after posedge number c.
  bit        exp_rdy  [CYC_MAX];
  bit        exp_rst  [CYC_MAX];
  bit        exp_en   [CYC_MAX];
  bit        exp_busy [CYC_MAX];
  bit        exp_done [CYC_MAX];
  int        exp_bub  [CYC_MAX];
  bit [31:0] feed_a   [CYC_MAX];
  bit [31:0] feed_b   [CYC_MAX];

  int lh [N][N];
  int th [N][N];
  int acc      [N][N];
  int acc_snap [N][N];
  int done_seen = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%0h want=%0h", nm, cyc, act, exp);
    end
  endtask

  // Per-cycle compare plus a downstream array model fed by the DUT's edge buses.
  initial begin
    bit [31:0] fa, fb;
    int idx;
    forever begin
      @(negedge clk);
      if (chk_en && cyc < CYC_MAX) begin
        chk("in_ready", in_ready, exp_rdy[cyc]);
        chk("acc_rst",  acc_rst,  exp_rst[cyc]);
        chk("acc_en",   acc_en,   exp_en[cyc]);
        chk("shift_en", shift_en, exp_en[cyc]);
        chk("busy",     busy,     exp_busy[cyc]);
        chk("done",     done,     exp_done[cyc]);
`ifdef FEEDER_BUBBLE_CNT_EN
        chk("bubble_cnt", bubble_cnt, exp_bub[cyc]);
`endif
        for (int i = 0; i < N; i++) begin
          idx = cyc - i - 1;
          fa = (idx >= 0) ? feed_a[idx] : 32'h0;
          fb = (idx >= 0) ? feed_b[idx] : 32'h0;
          chk($sformatf("left%0d", i), in_left_flat[i*DW +: DW], fa[i*DW +: DW]);
          chk($sformatf("top%0d", i),  in_top_flat[i*DW +: DW],  fb[i*DW +: DW]);
        end
      end
      for (int i = 0; i < N; i++) begin
        for (int d = N - 1; d > 0; d--) begin
          lh[i][d] = lh[i][d-1];
          th[i][d] = th[i][d-1];
        end
        lh[i][0] = int'(in_left_flat[i*DW +: DW]);
        th[i][0] = int'(in_top_flat[i*DW +: DW]);
      end
      if (acc_rst) begin
        for (int i = 0; i < N; i++) for (int j = 0; j < N; j++) acc[i][j] = 0;
      end else if (acc_en) begin
        for (int i = 0; i < N; i++)
          for (int j = 0; j < N; j++) acc[i][j] += lh[i][j] * th[j][i];
      end
      if (done === 1'b1) begin
        acc_snap = acc;
        done_seen++;
      end
    end
  end

  task automatic clear_from(input int c0, input int bub);
    for (int c = c0; c < CYC_MAX; c++) begin
      exp_rdy[c] = 0; exp_rst[c] = 0; exp_en[c] = 0; exp_busy[c] = 0; exp_done[c] = 0;
      exp_bub[c] = bub; feed_a[c] = 0; feed_b[c] = 0;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Runs one job from a cycle boundary; builds the expectation table first, then drives.
  task automatic run_job(input string nm, input int k, input bit [31:0] acol [4],
                         input bit [31:0] brow [4], input bit [7:0] bub, input bit poke,
                         output int lat);
    int s, ek, d, m, b, nb, ds0, sum;
    bit [31:0] av, bv;
    s = cyc + 1;
    clear_from(s, exp_bub[cyc]);
    exp_busy[s] = 1;
    exp_rst[s]  = 1;
    for (int c = s + 1; c < CYC_MAX; c++) exp_bub[c] = 0;
    m = 0; b = 0; nb = 0;
    while (b < k) begin
      exp_rdy[s+1+m] = 1; exp_en[s+1+m] = 1; exp_busy[s+1+m] = 1;
      if (bub[m]) begin
        nb++;
        for (int c = s + 2 + m; c < CYC_MAX; c++) exp_bub[c] = nb;
      end else begin
        feed_a[s+2+m] = acol[b];
        feed_b[s+2+m] = brow[b];
        b++;
      end
      m++;
    end
    ek = s + 1 + m;
    for (int c = ek; c < ek + 2 * N; c++) begin exp_en[c] = 1; exp_busy[c] = 1; end
    d = ek + 2 * N;
    exp_done[d] = 1;
    lat = d - s;
    ds0 = done_seen;

    start = 1'b1; k_len = 8'(k);
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    m = 0; b = 0;
    while (b < k) begin
      if (bub[m]) begin
        in_valid = 1'b0; a_col_flat = 32'hDEADBEEF; b_row_flat = 32'hDEADBEEF;
      end else begin
        in_valid = 1'b1; a_col_flat = acol[b]; b_row_flat = brow[b];
      end
      start = poke && (m == 1);
      @(posedge clk); #1;
      if (!bub[m]) b++;
      m++;
    end
    in_valid = 1'b0; start = 1'b0;
    a_col_flat = 32'hA5A5A5A5; b_row_flat = 32'h5A5A5A5A;
    while (cyc < d + 1) @(posedge clk);
    #1;
    chk({nm, "_done_count"}, done_seen - ds0, 1);
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        sum = 0;
        for (int kk = 0; kk < k; kk++) begin
          av = acol[kk]; bv = brow[kk];
          sum += int'(av[i*DW +: DW]) * int'(bv[j*DW +: DW]);
        end
        chk($sformatf("%s_acc%0d%0d", nm, i, j), acc_snap[i][j], sum);
      end
    end
  endtask

  initial begin
    bit [31:0] acol [4];
    bit [31:0] brow [4];
    int lat, ds0;

    rst_n = 1'b0; start = 1'b0; k_len = '0; in_valid = 1'b0;
    a_col_flat = 32'hA5A5A5A5; b_row_flat = 32'h5A5A5A5A;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", in_ready, 0);
    chk("rst_acc_rst",  acc_rst,  0);
    chk("rst_acc_en",   acc_en,   0);
    chk("rst_shift_en", shift_en, 0);
    chk("rst_busy",     busy,     0);
    chk("rst_done",     done,     0);
    chk("rst_left",     in_left_flat, 0);
    chk("rst_top",      in_top_flat,  0);
`ifdef FEEDER_BUBBLE_CNT_EN
    chk("rst_bubble",   bubble_cnt, 0);
`endif
    rst_n = 1'b1;
    clear_from(0, 0);
    chk_en = 1'b1;
    idle(2);

    // K=1 outer product
    acol = '{32'h04030201, 32'h0, 32'h0, 32'h0};
    brow = '{32'h07060504, 32'h0, 32'h0, 32'h0};
    run_job("k1", 1, acol, brow, 8'h00, 1'b0, lat);
    chk("k1_latency", lat, 10);
    chk("k1_acc33_literal", acc_snap[3][3], 28);
    chk("k1_acc02_literal", acc_snap[0][2], 6);
    idle(3);

    // K=4 identity times B
    acol = '{32'h00000001, 32'h00000100, 32'h00010000, 32'h01000000};
    brow = '{32'h03020100, 32'h0D0C0B0A, 32'h17161514, 32'h21201F1E};
    run_job("ident", 4, acol, brow, 8'h00, 1'b0, lat);
    chk("ident_latency", lat, 13);
    chk("ident_acc23_literal", acc_snap[2][3], 23);
    idle(3);

    // Same job with two bubbles
    run_job("bubble", 4, acol, brow, 8'b0000_1010, 1'b0, lat);
    chk("bubble_latency", lat, 15);
    chk("bubble_acc31_literal", acc_snap[3][1], 31);
`ifdef FEEDER_BUBBLE_CNT_EN
    chk("bubble_cnt_literal", bubble_cnt, 2);
`endif
    idle(3);

    // K=0
    run_job("k0", 0, acol, brow, 8'h00, 1'b0, lat);
    chk("k0_latency", lat, 9);
    chk("k0_acc00_literal", acc_snap[0][0], 0);
    idle(3);

    // Reset mid-stream
    chk_en = 1'b0;
    ds0 = done_seen;
    start = 1'b1; k_len = 8'd4;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b1; a_col_flat = 32'h11223344; b_row_flat = 32'h55667788;
    repeat (2) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("abort_in_ready", in_ready, 0);
    chk("abort_acc_en",   acc_en,   0);
    chk("abort_shift_en", shift_en, 0);
    chk("abort_busy",     busy,     0);
    chk("abort_done",     done,     0);
    chk("abort_left",     in_left_flat, 0);
    chk("abort_top",      in_top_flat,  0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    rst_n = 1'b1;
    idle(20);
    chk("abort_no_done", done_seen - ds0, 0);
    chk("abort_idle_busy", busy, 0);
    clear_from(cyc, 0);
    chk_en = 1'b1;
    idle(2);

    // Full-range data with a stray start while busy
    acol = '{32'hFF807F01, 32'h12345678, 32'h9ABCDEF0, 32'h0F1E2D3C};
    brow = '{32'hC3A55AFF, 32'h01020304, 32'h80808080, 32'hFEDCBA98};
    run_job("post", 4, acol, brow, 8'h00, 1'b1, lat);
    chk("post_latency", lat, 13);
    chk("post_acc00_literal", acc_snap[0][0], 1*255 + 120*4 + 240*128 + 60*152);
    idle(5);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
